// File: rtl/seq_pkg.sv
// Shared run-control definitions: state encoding, STP opcode and the bit positions
// of the decoder write-enable vector.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_t;

  localparam logic [4:0] STP_OPCODE = 5'b11111;

  localparam int WE_INSTR2  = 6;
  localparam int WE_DATA1   = 5;
  localparam int WE_DATA2   = 4;
  localparam int WE_RD      = 3;
  localparam int WE_RS      = 2;
  localparam int WE_MOVE_FP = 1;
  localparam int WE_PUSH_UP = 0;

  function automatic logic is_stp(input logic [15:0] instr);
    return instr[15:11] == STP_OPCODE;
  endfunction

endpackage

// File: rtl/seq_prime_timer.sv
// PRIME down-counter plus the latched state to enter once priming completes.
// done is combinational from the counter; start reloads both counter and target.
module seq_prime_timer
  import seq_pkg::*;
#(
  parameter int START_RUNNING = 0,
  parameter int PRIME_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] start_tgt,
  input  logic       tick,
  output logic       done,
  output logic [1:0] tgt
);

  localparam logic [1:0] CNT_INIT = 2'(PRIME_CYCLES - 1);

  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= CNT_INIT;
      tgt <= (START_RUNNING != 0) ? ST_RUN : ST_HALT;
    end else if (start) begin
      cnt <= CNT_INIT;
      tgt <= start_tgt;
    end else if (tick && cnt != 2'd0) begin
      cnt <= cnt - 2'd1;
    end
  end

  assign done = (cnt == 2'd0);

endmodule

// File: rtl/exec_sequencer.sv
// Run/halt/step sequencer gating decoder side effects; outputs are combinational
// from state, host loads are accepted only while halted with no run/step pending.
module exec_sequencer
  import seq_pkg::*;
#(
  parameter int START_RUNNING = 0,
  parameter int PRIME_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic [15:0] pc,
  input  logic [15:0] dec_instr_addr1,
  input  logic [15:0] dec_instr_addr2,
  input  logic [6:0]  dec_we,
  input  logic        dec_cnt_en,
  input  logic        dec_pc_sload,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        halt_req,
  input  logic        ld_valid,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_ready,
  output logic [15:0] instr_addr1,
  output logic [15:0] instr_addr2,
  output logic [15:0] instr_wdata2,
  output logic [6:0]  we,
  output logic        cnt_en,
  output logic        pc_sload,
  output logic        halted,
  output logic [15:0] exec_cnt
);

  seq_state_t state, state_nxt;
  logic       retire;
  logic       prime_start;
  logic [1:0] prime_start_tgt;
  logic       prime_done;
  logic [1:0] prime_tgt;
  logic       stp;
  logic       run_ok;
  logic       gate;

  seq_prime_timer #(
    .START_RUNNING(START_RUNNING),
    .PRIME_CYCLES (PRIME_CYCLES)
  ) u_prime (
    .clk      (clk),
    .reset    (reset),
    .start    (prime_start),
    .start_tgt(prime_start_tgt),
    .tick     (state == ST_PRIME),
    .done     (prime_done),
    .tgt      (prime_tgt)
  );

  assign stp    = is_stp(instr);
  assign run_ok = (state == ST_RUN) || (state == ST_STEP);
  assign gate   = run_ok && !reset;
  assign halted = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_PRIME;
      exec_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (retire) exec_cnt <= exec_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt       = state;
    retire          = 1'b0;
    ld_ready        = 1'b0;
    prime_start     = 1'b0;
    prime_start_tgt = ST_RUN;
    case (state)
      ST_PRIME: if (prime_done) state_nxt = seq_state_t'(prime_tgt);
      ST_RUN: begin
        // STP never retires; halt_req lets the current instruction finish
        if (stp) begin
          state_nxt = ST_HALT;
        end else begin
          retire = 1'b1;
          if (halt_req) state_nxt = ST_HALT;
        end
      end
      ST_STEP: begin
        retire    = !stp;
        state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (run_req) begin
          prime_start     = 1'b1;
          prime_start_tgt = ST_RUN;
          state_nxt       = ST_PRIME;
        end else if (step_req) begin
          prime_start     = 1'b1;
          prime_start_tgt = ST_STEP;
          state_nxt       = ST_PRIME;
        end else begin
          ld_ready = ld_valid && !reset;
        end
      end
      default: state_nxt = ST_PRIME;
    endcase

    we       = dec_we & {7{gate}};
    cnt_en   = dec_cnt_en && gate;
    pc_sload = dec_pc_sload && gate;
    if (ld_ready) we[WE_INSTR2] = 1'b1;

    // While stalled keep fetching pc/pc+1 so leaving HALT refetches fresh words
    instr_wdata2 = 16'd0;
    if (run_ok) begin
      instr_addr1 = dec_instr_addr1;
      instr_addr2 = dec_instr_addr2;
    end else begin
      instr_addr1 = pc;
      instr_addr2 = pc + 16'd1;
    end
    if (ld_ready) begin
      instr_addr2  = ld_addr;
      instr_wdata2 = ld_data;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench: two sequencers (run-from-reset/1 prime cycle, halt-from-reset/2 prime cycles)
// share stimulus and are compared against a behavioural model of the run-control rules.
module tb_exec_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0000, pc = 16'h0000;
  logic [15:0] dec_instr_addr1 = 16'h0, dec_instr_addr2 = 16'h0;
  logic [6:0]  dec_we = 7'h0;
  logic        dec_cnt_en = 1'b0, dec_pc_sload = 1'b0;
  logic        run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0, ld_valid = 1'b0;
  logic [15:0] ld_addr = 16'h0, ld_data = 16'h0;

  logic        ld_ready_o [2];
  logic [15:0] a1_o [2];
  logic [15:0] a2_o [2];
  logic [15:0] wd_o [2];
  logic [6:0]  we_o [2];
  logic        cnt_en_o [2];
  logic        pc_sload_o [2];
  logic        halted_o [2];
  logic [15:0] exec_cnt_o [2];

  int checks = 0;
  int failures = 0;

  exec_sequencer #(.START_RUNNING(1), .PRIME_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .instr(instr), .pc(pc),
    .dec_instr_addr1(dec_instr_addr1), .dec_instr_addr2(dec_instr_addr2),
    .dec_we(dec_we), .dec_cnt_en(dec_cnt_en), .dec_pc_sload(dec_pc_sload),
    .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready_o[0]), .instr_addr1(a1_o[0]), .instr_addr2(a2_o[0]),
    .instr_wdata2(wd_o[0]), .we(we_o[0]), .cnt_en(cnt_en_o[0]),
    .pc_sload(pc_sload_o[0]), .halted(halted_o[0]), .exec_cnt(exec_cnt_o[0])
  );

  exec_sequencer #(.START_RUNNING(0), .PRIME_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .instr(instr), .pc(pc),
    .dec_instr_addr1(dec_instr_addr1), .dec_instr_addr2(dec_instr_addr2),
    .dec_we(dec_we), .dec_cnt_en(dec_cnt_en), .dec_pc_sload(dec_pc_sload),
    .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready_o[1]), .instr_addr1(a1_o[1]), .instr_addr2(a2_o[1]),
    .instr_wdata2(wd_o[1]), .we(we_o[1]), .cnt_en(cnt_en_o[1]),
    .pc_sload(pc_sload_o[1]), .halted(halted_o[1]), .exec_cnt(exec_cnt_o[1])
  );

  typedef struct packed {
    logic        ld_ready;
    logic [15:0] a1;
    logic [15:0] a2;
    logic [15:0] wd;
    logic [6:0]  we;
    logic        cnt_en;
    logic        pc_sload;
    logic        halted;
    logic [15:0] exec_cnt;
  } obs_t;

  // Reference model: what the core is doing, how many priming cycles remain,
  // where it goes afterwards and how many instructions have retired.
  localparam int MD_PRIMING = 10, MD_RUNNING = 11, MD_STEPPING = 12, MD_STOPPED = 13;
  localparam int START_RUN [2] = '{1, 0};
  localparam int PRIMES    [2] = '{1, 2};

  int          m_mode [2] = '{MD_PRIMING, MD_PRIMING};
  int          m_left [2] = '{0, 1};
  int          m_tgt  [2] = '{MD_RUNNING, MD_STOPPED};
  int          m_cnt  [2] = '{0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_mode[k] <= MD_PRIMING;
        m_left[k] <= PRIMES[k] - 1;
        m_tgt[k]  <= START_RUN[k] != 0 ? MD_RUNNING : MD_STOPPED;
        m_cnt[k]  <= 0;
      end else if (m_mode[k] == MD_PRIMING) begin
        if (m_left[k] == 0) m_mode[k] <= m_tgt[k];
        else m_left[k] <= m_left[k] - 1;
      end else if (m_mode[k] == MD_RUNNING) begin
        if (instr[15:11] == 5'b11111) m_mode[k] <= MD_STOPPED;
        else begin
          m_cnt[k] <= (m_cnt[k] + 1) % 65536;
          if (halt_req) m_mode[k] <= MD_STOPPED;
        end
      end else if (m_mode[k] == MD_STEPPING) begin
        if (instr[15:11] != 5'b11111) m_cnt[k] <= (m_cnt[k] + 1) % 65536;
        m_mode[k] <= MD_STOPPED;
      end else if (run_req || step_req) begin
        m_tgt[k]  <= run_req ? MD_RUNNING : MD_STEPPING;
        m_left[k] <= PRIMES[k] - 1;
        m_mode[k] <= MD_PRIMING;
      end
    end
  end

  function automatic obs_t model_obs(int k);
    obs_t o;
    bit executing = (m_mode[k] == MD_RUNNING) || (m_mode[k] == MD_STEPPING);
    bit live = executing && !reset;
    bit load = (m_mode[k] == MD_STOPPED) && !reset && ld_valid && !run_req && !step_req;
    o.ld_ready = load;
    o.we       = live ? dec_we : 7'b0;
    if (load) o.we = o.we | 7'b1000000;
    o.cnt_en   = live && dec_cnt_en;
    o.pc_sload = live && dec_pc_sload;
    o.halted   = (m_mode[k] == MD_STOPPED);
    o.exec_cnt = 16'(m_cnt[k]);
    o.a1       = executing ? dec_instr_addr1 : pc;
    o.a2       = executing ? dec_instr_addr2 : 16'((32'(pc) + 1) % 65536);
    o.wd       = 16'h0;
    if (load) begin
      o.a2 = ld_addr;
      o.wd = ld_data;
    end
    return o;
  endfunction

  function automatic obs_t dut_obs(int k);
    obs_t o;
    o.ld_ready = ld_ready_o[k];
    o.a1       = a1_o[k];
    o.a2       = a2_o[k];
    o.wd       = wd_o[k];
    o.we       = we_o[k];
    o.cnt_en   = cnt_en_o[k];
    o.pc_sload = pc_sload_o[k];
    o.halted   = halted_o[k];
    o.exec_cnt = exec_cnt_o[k];
    return o;
  endfunction

  task automatic rand_dec();
    dec_we          = 7'($urandom);
    dec_cnt_en      = 1'($urandom);
    dec_pc_sload    = 1'($urandom);
    dec_instr_addr1 = 16'($urandom);
    dec_instr_addr2 = 16'($urandom);
    pc              = 16'($urandom);
    instr           = 16'($urandom_range(0, 16'hF7FF));
    ld_addr         = 16'($urandom);
    ld_data         = 16'($urandom);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, a;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      rand_dec();
      ld_valid = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({we_o[k], cnt_en_o[k], pc_sload_o[k], ld_ready_o[k]} !== 10'b0) begin
          $display("FAIL reset_enables dut%0d got=%b exp=0", k,
                   {we_o[k], cnt_en_o[k], pc_sload_o[k], ld_ready_o[k]});
          failures++;
        end
      end
      adv();
    end
    reset = 1'b0;
    ld_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rand_dec();
      dec_cnt_en = 1'b1;
      dec_we = 7'b0001000;
      @(negedge clk);
      checks++;
      if (c == 0 && (we_o[0] !== 7'b0 || cnt_en_o[0] !== 1'b0)) begin
        $display("FAIL prime_enables got we=%b cnt_en=%b exp 0/0", we_o[0], cnt_en_o[0]);
        failures++;
      end
      checks++;
      if (c > 0 && (we_o[0] !== 7'b0001000 || cnt_en_o[0] !== 1'b1)) begin
        $display("FAIL run_enables got we=%b cnt_en=%b exp 0001000/1", we_o[0], cnt_en_o[0]);
        failures++;
      end
      checks++;
      if (exec_cnt_o[0] !== 16'(c == 0 ? 0 : c - 1)) begin
        $display("FAIL exec_cnt_start got=%0d exp=%0d", exec_cnt_o[0], c == 0 ? 0 : c - 1);
        failures++;
      end
      for (int k = 0; k < 2; k++) begin
        e = model_obs(k); a = dut_obs(k); checks++;
        if (a !== e) begin
          $display("FAIL after_reset dut%0d t=%0t got=%h exp=%h", k, $time, a, e);
          failures++;
        end
      end
      adv();
    end
  endtask

  task automatic test_run_random();
    obs_t e, a;
    for (int c = 0; c < 20; c++) begin
      rand_dec();
      ld_valid = 1'($urandom);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        e = model_obs(k); a = dut_obs(k); checks++;
        if (a !== e) begin
          $display("FAIL run_random dut%0d t=%0t got=%h exp=%h", k, $time, a, e);
          failures++;
        end
      end
      adv();
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_stp();
    obs_t e, a;
    int c0;
    rand_dec();
    instr = 16'hF800;
    c0 = m_cnt[0];
    adv();
    @(negedge clk);
    checks++;
    if (halted_o[0] !== 1'b1 || exec_cnt_o[0] !== 16'(c0)) begin
      $display("FAIL stp_halt got halted=%b cnt=%0d exp 1/%0d", halted_o[0], exec_cnt_o[0], c0);
      failures++;
    end
    checks++;
    if (a1_o[0] !== pc || a2_o[0] !== 16'(pc + 16'd1)) begin
      $display("FAIL stp_addr got %h/%h exp %h/%h", a1_o[0], a2_o[0], pc, 16'(pc + 16'd1));
      failures++;
    end
    for (int k = 0; k < 2; k++) begin
      e = model_obs(k); a = dut_obs(k); checks++;
      if (a !== e) begin
        $display("FAIL stp_state dut%0d got=%h exp=%h", k, a, e);
        failures++;
      end
    end
    adv();
  endtask

  task automatic test_load();
    obs_t e, a;
    rand_dec();
    ld_valid = 1'b1;
    ld_addr = 16'h0040;
    ld_data = 16'h2805;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ld_ready_o[k] !== 1'b1 || we_o[k] !== 7'b1000000 ||
          a2_o[k] !== 16'h0040 || wd_o[k] !== 16'h2805) begin
        $display("FAIL load_accept dut%0d got rdy=%b we=%b a2=%h wd=%h exp 1/1000000/0040/2805",
                 k, ld_ready_o[k], we_o[k], a2_o[k], wd_o[k]);
        failures++;
      end
    end
    adv();
    run_req = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ld_ready_o[k] !== 1'b0 || we_o[k][6] !== 1'b0) begin
        $display("FAIL load_vs_run dut%0d got rdy=%b we6=%b exp 0/0", k, ld_ready_o[k], we_o[k][6]);
        failures++;
      end
    end
    adv();
    run_req = 1'b0;
    ld_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rand_dec();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        e = model_obs(k); a = dut_obs(k); checks++;
        if (a !== e) begin
          $display("FAIL load_then_run dut%0d t=%0t got=%h exp=%h", k, $time, a, e);
          failures++;
        end
      end
      adv();
    end
  endtask

  task automatic test_step();
    obs_t e, a;
    int c0;
    rand_dec();
    halt_req = 1'b1;
    adv();
    halt_req = 1'b0;
    step_req = 1'b1;
    adv();
    step_req = 1'b0;
    c0 = m_cnt[1];
    for (int c = 0; c < 5; c++) begin
      rand_dec();
      @(negedge clk);
      checks++;
      if (c < 2 && (we_o[1] !== 7'b0 || cnt_en_o[1] !== 1'b0 || pc_sload_o[1] !== 1'b0)) begin
        $display("FAIL step_prime got we=%b cnt_en=%b exp 0/0", we_o[1], cnt_en_o[1]);
        failures++;
      end
      checks++;
      if (c == 2 && (we_o[1] !== dec_we || cnt_en_o[1] !== dec_cnt_en || halted_o[1] !== 1'b0)) begin
        $display("FAIL step_exec got we=%b cnt_en=%b exp %b/%b", we_o[1], cnt_en_o[1], dec_we, dec_cnt_en);
        failures++;
      end
      checks++;
      if (c >= 3 && (halted_o[1] !== 1'b1 || exec_cnt_o[1] !== 16'(c0 + 1))) begin
        $display("FAIL step_done got halted=%b cnt=%0d exp 1/%0d", halted_o[1], exec_cnt_o[1], c0 + 1);
        failures++;
      end
      for (int k = 0; k < 2; k++) begin
        e = model_obs(k); a = dut_obs(k); checks++;
        if (a !== e) begin
          $display("FAIL step_seq dut%0d t=%0t got=%h exp=%h", k, $time, a, e);
          failures++;
        end
      end
      adv();
    end
  endtask

  task automatic test_halt_run();
    int c0;
    rand_dec();
    run_req = 1'b1;
    adv();
    run_req = 1'b0;
    repeat (3) adv();
    halt_req = 1'b1;
    run_req = 1'b1;
    c0 = m_cnt[0];
    adv();
    halt_req = 1'b0;
    run_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (halted_o[k] !== 1'b1 || exec_cnt_o[k] !== 16'(m_cnt[k])) begin
        $display("FAIL halt_wins dut%0d got halted=%b cnt=%0d exp 1/%0d", k, halted_o[k], exec_cnt_o[k], m_cnt[k]);
        failures++;
      end
    end
    checks++;
    if (exec_cnt_o[0] !== 16'(c0 + 1)) begin
      $display("FAIL halt_retire got=%0d exp=%0d", exec_cnt_o[0], c0 + 1);
      failures++;
    end
    adv();
  endtask

  task automatic test_wrap();
    obs_t e, a;
    int n;
    rand_dec();
    pc = 16'hFFFF;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (a2_o[k] !== 16'h0000 || a1_o[k] !== 16'hFFFF) begin
        $display("FAIL pc_wrap dut%0d got a1=%h a2=%h exp ffff/0000", k, a1_o[k], a2_o[k]);
        failures++;
      end
    end
    adv();
    run_req = 1'b1;
    adv();
    run_req = 1'b0;
    n = 0;
    while (exec_cnt_o[0] !== 16'hFFFF && n < 70000) begin
      adv();
      n++;
    end
    @(negedge clk);
    checks++;
    if (n >= 70000 || m_cnt[0] != 65535) begin
      $display("FAIL wrap_reach got cnt=%0d model=%0d exp 65535", exec_cnt_o[0], m_cnt[0]);
      failures++;
    end
    adv();
    @(negedge clk);
    checks++;
    if (exec_cnt_o[0] !== 16'h0000) begin
      $display("FAIL exec_wrap got=%h exp=0000", exec_cnt_o[0]);
      failures++;
    end
    for (int k = 0; k < 2; k++) begin
      e = model_obs(k); a = dut_obs(k); checks++;
      if (a !== e) begin
        $display("FAIL wrap_state dut%0d got=%h exp=%h", k, a, e);
        failures++;
      end
    end
    adv();
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    for (int c = 0; c < 400; c++) begin
      rand_dec();
      reset    = ($urandom_range(0, 49) == 0);
      run_req  = ($urandom_range(0, 9) == 0);
      step_req = ($urandom_range(0, 9) == 0);
      halt_req = ($urandom_range(0, 9) == 0);
      ld_valid = 1'($urandom);
      if ($urandom_range(0, 9) == 0) instr = {5'b11111, 11'($urandom)};
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        e = model_obs(k); a = dut_obs(k); checks++;
        if (a !== e) begin
          $display("FAIL back_to_back dut%0d t=%0t got=%h exp=%h", k, $time, a, e);
          failures++;
        end
      end
      adv();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_random();
    test_stp();
    test_load();
    test_step();
    test_halt_run();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
